udp_payload_packer: RTL and testbench
=====================================

Name: udp_payload_packer

Overview:
- Sits between the 16-bit-output async payload FIFO (read side on clk125M domain) and eth_udp_tx_gmii.
- Waits until one full frame of words is buffered, prefetches the first word, then fires tx_en_pulse.
- Serialises 16-bit words MSB-byte-first onto payload_dat for every payload_req cycle, reading exactly PAYLOAD_BYTES/2 words per frame.
- Replaces free-running byte-phase toggling with request-driven phase tracking; adds frame counting and underflow/overrun flags.

Parameters:
- PAYLOAD_BYTES, 800, UDP payload length per frame; must be even and in 2..65534 (elaboration error otherwise).
- WORD_W, 16, FIFO word width; fixed at 16.

Ports:
- clk125M  in  1  system/GMII clock.
- udp_gmii_rst_n  in  1  async active-low reset.
- enable  in  1  allows new frames to start; sampled only in IDLE.
- frame_avail  in  1  FIFO holds >= PAYLOAD_BYTES/2 words (prog-full style level flag).
- fifo_empty  in  1  FIFO empty.
- fifo_dout  in  16  FIFO read data; standard mode, valid 1 cycle after fifo_rd_en, held until the next read.
- fifo_rd_en  out  1  FIFO read strobe.
- tx_en_pulse  out  1  one-cycle frame start to eth_udp_tx_gmii.
- tx_done  in  1  frame-complete pulse from eth_udp_tx_gmii.
- payload_req  in  1  byte request from eth_udp_tx_gmii; byte consumed in the same cycle.
- payload_dat  out  8  payload byte; must be valid in any cycle in which payload_req=1.
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  32  frames completed (tx_done seen); wraps at 2^32.
- err_underflow  out  1  sticky; read needed while fifo_empty.
- err_overrun  out  1  sticky; payload_req after the last byte of the frame.

Behaviour:
- Reset: async on udp_gmii_rst_n low, synchronous release.
  - State goes to IDLE.
  - Outputs: fifo_rd_en, tx_en_pulse, busy, err_underflow and err_overrun = 0; payload_dat = 8'h00; frame_cnt = 0.
  - Internal: word_reg = 0, byte_cnt = 0, phase = 0.
  - A reset mid-frame abandons the frame. Leftover FIFO words are not flushed.
- States:
  - IDLE: when enable && frame_avail && !fifo_empty, go to PREFETCH.
  - PREFETCH (1 cycle): fifo_rd_en = 1; go to LOAD.
  - LOAD (1 cycle): word_reg <= fifo_dout; byte_cnt <= 0; phase <= 0; go to ARM.
  - ARM (1 cycle): tx_en_pulse = 1; go to STREAM.
  - STREAM: serialise bytes as described below.
  - WAIT_DONE: on tx_done, frame_cnt += 1 and go to IDLE.
- payload_dat (combinational from registers):
  - word_reg[15:8] when phase=0; word_reg[7:0] when phase=1.
  - Forced to 8'h00 when byte_cnt >= PAYLOAD_BYTES.
  - Forced to 8'h00 when the current word was an underflow substitute.
- STREAM, on each payload_req=1 cycle:
  - byte_cnt += 1 and phase toggles.
  - If phase=0 and the current word is not the last word, assert fifo_rd_en this cycle.
    - If fifo_empty at that point, do not read; set err_underflow and mark the next word as a substitute.
  - If phase=1, word_reg <= fifo_dout. The read was issued at least 1 cycle earlier, so the data is stable.
  - When byte_cnt reaches PAYLOAD_BYTES-1 and is consumed, go to WAIT_DONE.
- Words read per frame: exactly PAYLOAD_BYTES/2, including the prefetch. Reads never occur in IDLE, ARM or WAIT_DONE.
- Gaps in payload_req: state, phase and payload_dat hold; no read is issued.
- payload_req outside STREAM: err_overrun is set and payload_dat = 8'h00. In WAIT_DONE this is the overrun case.
- tx_done outside WAIT_DONE: ignored, and frame_cnt is unchanged.
- tx_done arriving in the same cycle as the last byte: accepted on the next cycle only if it is still high. The transmitter pulses tx_done after the final byte, so no loss occurs.
- enable falling mid-frame: the current frame completes.
- Latency: IDLE condition true to tx_en_pulse is 3 cycles (PREFETCH, LOAD, ARM).

Test Plan:
- Load 400 words 0x0001..0x0190, assert frame_avail, enable=1, payload_req held high for 800 cycles after tx_en_pulse -> bytes 00 01 00 02 ... 01 90; exactly 400 fifo_rd_en cycles; tx_en_pulse 3 cycles after frame_avail; frame_cnt=1 after tx_done.
- Same frame, payload_req toggling 1-0-1-0 with random 0-3-cycle gaps -> identical byte sequence; no reads during gaps; byte_cnt ends at 800.
- Only 399 words loaded, frame_avail forced high -> err_underflow=1; last two bytes 00 00; total reads = 399 (the prefetch plus 398).
- Extra payload_req cycle after byte 800 -> err_overrun=1; payload_dat=00; no fifo_rd_en; frame_cnt still increments on tx_done.
- Assert udp_gmii_rst_n low at byte 300 -> all outputs 0 in the same cycle; after release, a new full frame with 400 fresh words streams correctly from byte 0.
- enable=0 with frame_avail=1 -> no tx_en_pulse and no reads; raise enable -> frame starts 3 cycles later. Two back-to-back frames -> frame_cnt=2 and no tx_en_pulse before the first tx_done.

Source files
------------

// File: rtl/udp_payload_packer.sv
// udp_payload_packer
//   Reads 16-bit words from the payload FIFO (read side on clk125M) and
//   serialises them MSB byte first to eth_udp_tx_gmii. A frame starts only
//   once a full frame of words is buffered. The first word is prefetched
//   before tx_en_pulse fires. After that, one byte goes out for every
//   payload_req cycle.
//
// Ports
//   clk125M        system / GMII clock
//   udp_gmii_rst_n async active-low reset (synchronous release expected)
//   enable         permits new frames; looked at only while idle
//   frame_avail    FIFO holds at least PAYLOAD_BYTES/2 words
//   fifo_empty     FIFO empty flag
//   fifo_dout      FIFO read data, valid the cycle after fifo_rd_en, then held
//   fifo_rd_en     FIFO read strobe
//   tx_en_pulse    one-cycle frame start towards eth_udp_tx_gmii
//   tx_done        frame-complete pulse from eth_udp_tx_gmii
//   payload_req    byte request; the byte is consumed in the same cycle
//   payload_dat    payload byte, valid whenever payload_req is high
//   busy           high in every state except IDLE
//   frame_cnt      number of completed frames (wraps)
//   err_underflow  sticky: a word was needed while the FIFO was empty
//   err_overrun    sticky: byte requested outside the streaming window
module udp_payload_packer #(
    parameter int PAYLOAD_BYTES = 800,
    parameter int WORD_W        = 16
) (
    input  logic              clk125M,
    input  logic              udp_gmii_rst_n,
    input  logic              enable,
    input  logic              frame_avail,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              tx_en_pulse,
    input  logic              tx_done,
    input  logic              payload_req,
    output logic [7:0]        payload_dat,
    output logic              busy,
    output logic [31:0]       frame_cnt,
    output logic              err_underflow,
    output logic              err_overrun
);

    if ((PAYLOAD_BYTES < 2) || (PAYLOAD_BYTES > 65534) || ((PAYLOAD_BYTES % 2) != 0)) begin : g_bad_len
        $error("udp_payload_packer: PAYLOAD_BYTES must be even and within 2..65534");
    end
    if (WORD_W != 16) begin : g_bad_width
        $error("udp_payload_packer: WORD_W must be 16");
    end

    localparam logic [15:0] LAST_BYTE  = 16'(PAYLOAD_BYTES - 1);
    localparam logic [15:0] LAST_WORD0 = 16'(PAYLOAD_BYTES - 2);
    localparam logic [15:0] END_CNT    = 16'(PAYLOAD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_LOAD,
        ST_ARM,
        ST_STREAM,
        ST_WAIT_DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] word_reg;
    logic [15:0] byte_cnt;
    logic        phase;
    logic        sub_pend;   // the word currently being fetched is an underflow substitute
    logic        sub_cur;    // the word in word_reg is an underflow substitute
    logic        take;
    logic        need_read;
    logic [7:0]  byte_sel;

    assign take = (state == ST_STREAM) && payload_req;
    // The next word is fetched when the high byte of the current word goes
    // out. The last word of the frame has no successor, so it triggers no read.
    assign need_read = take && !phase && (byte_cnt < LAST_WORD0);

    always_ff @(posedge clk125M or negedge udp_gmii_rst_n) begin
        if (!udp_gmii_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable && frame_avail && !fifo_empty) begin
                    next_state = ST_PREFETCH;
                end
            end
            ST_PREFETCH: next_state = ST_LOAD;
            ST_LOAD:     next_state = ST_ARM;
            ST_ARM:      next_state = ST_STREAM;
            ST_STREAM: begin
                if (take && (byte_cnt == LAST_BYTE)) begin
                    next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en  = 1'b0;
        tx_en_pulse = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_PREFETCH: fifo_rd_en  = 1'b1;
            ST_ARM:      tx_en_pulse = 1'b1;
            ST_STREAM:   fifo_rd_en  = need_read && !fifo_empty;
            default: ;
        endcase
    end

    assign byte_sel    = phase ? word_reg[7:0] : word_reg[15:8];
    assign payload_dat = ((state == ST_STREAM) && (byte_cnt < END_CNT) && !sub_cur) ? byte_sel : 8'h00;

    always_ff @(posedge clk125M or negedge udp_gmii_rst_n) begin
        if (!udp_gmii_rst_n) begin
            word_reg      <= '0;
            byte_cnt      <= '0;
            phase         <= 1'b0;
            sub_pend      <= 1'b0;
            sub_cur       <= 1'b0;
            frame_cnt     <= '0;
            err_underflow <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            if (state == ST_LOAD) begin
                word_reg <= fifo_dout;
                byte_cnt <= '0;
                phase    <= 1'b0;
                sub_pend <= 1'b0;
                sub_cur  <= 1'b0;
            end else if (take) begin
                byte_cnt <= byte_cnt + 16'd1;
                phase    <= ~phase;
                if (need_read && fifo_empty) begin
                    err_underflow <= 1'b1;
                    sub_pend      <= 1'b1;
                end
                // The low byte leaves now. The read was issued at least one
                // cycle ago, so fifo_dout already holds the next word.
                if (phase && (byte_cnt != LAST_BYTE)) begin
                    word_reg <= fifo_dout;
                    sub_cur  <= sub_pend;
                    sub_pend <= 1'b0;
                end
            end
            if (payload_req && (state != ST_STREAM)) begin
                err_overrun <= 1'b1;
            end
            if ((state == ST_WAIT_DONE) && tx_done) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_payload_packer.sv
// Bench for udp_payload_packer: a FIFO model feeds the design, and a
// transmitter model issues payload_req. Captured bytes are compared with
// a reference built from the words pushed into the FIFO.
module tb_udp_payload_packer;

    localparam int PB = 800;
    localparam int NW = PB / 2;

    logic        clk125M = 1'b0;
    logic        udp_gmii_rst_n;
    logic        enable;
    logic        frame_avail;
    logic        fifo_empty;
    logic [15:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic        tx_en_pulse;
    logic        tx_done;
    logic        payload_req;
    logic [7:0]  payload_dat;
    logic        busy;
    logic [31:0] frame_cnt;
    logic        err_underflow;
    logic        err_overrun;

    int errors = 0;
    int checks = 0;

    udp_payload_packer #(.PAYLOAD_BYTES(PB), .WORD_W(16)) dut (
        .clk125M       (clk125M),
        .udp_gmii_rst_n(udp_gmii_rst_n),
        .enable        (enable),
        .frame_avail   (frame_avail),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .tx_en_pulse   (tx_en_pulse),
        .tx_done       (tx_done),
        .payload_req   (payload_req),
        .payload_dat   (payload_dat),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .err_underflow (err_underflow),
        .err_overrun   (err_overrun)
    );

    always #4 clk125M = ~clk125M;

    // FIFO model: standard-mode read, data appears the cycle after the strobe
    logic [15:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_avail = 1'b0;
    logic        flush = 1'b0;
    logic        rd_now = 1'b0;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign frame_avail = force_avail || ((wr_ptr - rd_ptr) >= NW);

    always @(posedge clk125M) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (rd_now && (wr_ptr != rd_ptr)) begin
            fifo_dout <= mem[rd_ptr & 4095];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Monitor samples mid-cycle, away from the active edge
    logic [7:0] got [$];
    int         rd_count = 0;
    int         gap_reads = 0;
    int         pulse_count = 0;
    logic       streaming = 1'b0;

    always @(negedge clk125M) begin
        rd_now <= fifo_rd_en;
        if (fifo_rd_en) rd_count <= rd_count + 1;
        if (fifo_rd_en && !payload_req && streaming) gap_reads <= gap_reads + 1;
        if (payload_req) got.push_back(payload_dat);
        if (tx_en_pulse) pulse_count <= pulse_count + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int mrd = 0;  // reference model's read position in the FIFO word stream

    task automatic tick();
        @(posedge clk125M);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_words(input int n, input bit incr, input int first);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr & 4095] = incr ? 16'(first + i) : 16'($urandom);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            #2;
            if (tx_en_pulse) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic stream_bytes(input int n, input int max_gap);
        int g;
        streaming = 1'b1;
        for (int i = 0; i < n; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                payload_req = 1'b0;
                tick();
            end
            payload_req = 1'b1;
            tick();
        end
        payload_req = 1'b0;
        streaming   = 1'b0;
    endtask

    // A frame takes up to NW words in FIFO order; any word missing from the
    // FIFO goes out as two zero bytes.
    task automatic verify_frame(input string tag, input int gbase, input int rbase);
        int          avail;
        int          nread;
        logic [15:0] w;
        logic [7:0]  eb;
        avail = wr_ptr - mrd;
        nread = (avail < NW) ? avail : NW;
        check({tag, "_nbytes"}, got.size() - gbase, PB);
        for (int k = 0; k < PB; k++) begin
            if ((k / 2) < nread) begin
                w  = mem[(mrd + k / 2) & 4095];
                eb = ((k % 2) == 0) ? w[15:8] : w[7:0];
            end else begin
                eb = 8'h00;
            end
            check($sformatf("%s_byte%0d", tag, k), got[gbase + k], eb);
        end
        check({tag, "_reads"}, rd_count - rbase, nread);
        mrd = mrd + nread;
    endtask

    task automatic finish_frame(input string tag, input int exp_cnt);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        #2;
        check({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
        check({tag, "_tx_en"}, tx_en_pulse, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dat"}, payload_dat, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_underflow"}, err_underflow, 0);
        check({tag, "_overrun"}, err_overrun, 0);
    endtask

    initial begin
        int lat;
        int gbase;
        int rbase;
        int pbase;
        int gr;

        udp_gmii_rst_n = 1'b1;
        enable         = 1'b0;
        tx_done        = 1'b0;
        payload_req    = 1'b0;
        #1;
        udp_gmii_rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        udp_gmii_rst_n = 1'b1;
        tick();

        // Frame 1: enable held low first, then a counting pattern, continuous requests
        load_words(NW, 1'b1, 1);
        pbase = pulse_count;
        rbase = rd_count;
        repeat (10) tick();
        check("dis_no_pulse", pulse_count - pbase, 0);
        check("dis_no_reads", rd_count - rbase, 0);
        check("dis_idle", busy, 0);
        gbase  = got.size();
        enable = 1'b1;
        wait_pulse(lat);
        enable = 1'b0;
        check("f1_latency", lat, 3);
        tick();
        stream_bytes(PB, 0);
        verify_frame("f1", gbase, rbase);
        check("f1_underflow", err_underflow, 0);
        check("f1_overrun", err_overrun, 0);
        finish_frame("f1", 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        #2;
        check("stray_tx_done", frame_cnt, 1);

        // Frame 2: random data, requests with random gaps
        load_words(NW, 1'b0, 0);
        gbase  = got.size();
        rbase  = rd_count;
        gr     = gap_reads;
        enable = 1'b1;
        wait_pulse(lat);
        enable = 1'b0;
        check("f2_latency", lat, 3);
        tick();
        stream_bytes(PB, 3);
        verify_frame("f2", gbase, rbase);
        check("f2_gap_reads", gap_reads - gr, 0);
        check("f2_byte_cnt_end", dut.byte_cnt, PB);
        finish_frame("f2", 2);

        // Frame 3: one word short, frame_avail forced
        load_words(NW - 1, 1'b0, 0);
        force_avail = 1'b1;
        gbase  = got.size();
        rbase  = rd_count;
        enable = 1'b1;
        wait_pulse(lat);
        enable = 1'b0;
        check("f3_latency", lat, 3);
        tick();
        stream_bytes(PB, 1);
        verify_frame("f3", gbase, rbase);
        check("f3_underflow", err_underflow, 1);
        check("f3_overrun", err_overrun, 0);
        finish_frame("f3", 3);
        force_avail = 1'b0;

        // Frame 4: an extra request after the final byte
        load_words(NW, 1'b0, 0);
        gbase  = got.size();
        rbase  = rd_count;
        enable = 1'b1;
        wait_pulse(lat);
        enable = 1'b0;
        tick();
        stream_bytes(PB, 0);
        verify_frame("f4", gbase, rbase);
        check("f4_overrun_before", err_overrun, 0);
        payload_req = 1'b1;
        #2;
        check("f4_extra_dat", payload_dat, 0);
        check("f4_extra_rd_en", fifo_rd_en, 0);
        tick();
        payload_req = 1'b0;
        #1;
        check("f4_overrun", err_overrun, 1);
        finish_frame("f4", 4);

        // Two back-to-back frames with enable held high
        load_words(2 * NW, 1'b0, 0);
        pbase  = pulse_count;
        gbase  = got.size();
        rbase  = rd_count;
        enable = 1'b1;
        wait_pulse(lat);
        check("b1_latency", lat, 3);
        tick();
        stream_bytes(PB, 0);
        verify_frame("b1", gbase, rbase);
        check("b1_single_pulse", pulse_count - pbase, 1);
        finish_frame("b1", 5);
        gbase = got.size();
        rbase = rd_count;
        wait_pulse(lat);
        enable = 1'b0;
        check("b2_latency", lat, 3);
        tick();
        stream_bytes(PB, 2);
        verify_frame("b2", gbase, rbase);
        finish_frame("b2", 6);
        check("b2_pulses", pulse_count - pbase, 2);

        // Reset at byte 300, then a fresh frame
        load_words(NW, 1'b0, 0);
        enable = 1'b1;
        wait_pulse(lat);
        enable = 1'b0;
        tick();
        stream_bytes(300, 0);
        udp_gmii_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mrd   = wr_ptr;
        tick();
        udp_gmii_rst_n = 1'b1;
        tick();
        load_words(NW, 1'b1, 16'h1000);
        gbase  = got.size();
        rbase  = rd_count;
        enable = 1'b1;
        wait_pulse(lat);
        enable = 1'b0;
        check("r1_latency", lat, 3);
        tick();
        stream_bytes(PB, 1);
        verify_frame("r1", gbase, rbase);
        check("r1_underflow", err_underflow, 0);
        finish_frame("r1", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
